// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction-memory and decoder bus for the ifetch stage
// Purpose: groups the instruction-memory read port and the decoder hand-off
//          signals of the fetch stage into one bundle.
// Signals:
//   imem_addr  fetch -> imem     instruction-memory address (= pc)
//   imem_rdata imem  -> fetch    combinational instruction word
//   o          fetch -> decoder  instruction word, NOP outside EXEC
//   ir_vld     fetch -> decoder  instruction valid (EXEC only)
//   h          decoder -> fetch  halt indication
//   pcwe       decoder -> fetch  taken-branch PC write enable
//   br_tgt     alu   -> fetch    branch target
// Modports: master = fetch stage, slave = memory/decoder side.
interface ifetch_if #(
   parameter int AW = 8
);
   logic [AW-1:0] imem_addr;
   logic [15:0]   imem_rdata;
   logic [15:0]   o;
   logic          ir_vld;
   logic          h;
   logic          pcwe;
   logic [15:0]   br_tgt;

   modport master (
      output imem_addr, o, ir_vld,
      input  imem_rdata, h, pcwe, br_tgt
   );

   modport slave (
      input  imem_addr, o, ir_vld,
      output imem_rdata, h, pcwe, br_tgt
   );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch and sequencing stage of the 16-bit pu core
// Purpose: owns the PC, fetches one word per instruction into the IR, presents
//          it to the decoder for one or more EXEC cycles and picks the next PC
//          (sequential, branch, or halt). Two cycles per unstalled instruction.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   run     in   start request, only looked at in IDLE
//   stall   in   holds the current instruction in EXEC
//   bus     ifetch_if.master  imem port and decoder hand-off
//   pc      out  PC of the instruction held in the IR
//   halted  out  core stopped by HALT
//   icnt    out  retired-instruction counter, saturating
module ifetch #(
   parameter int            AW       = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            stall,
   ifetch_if.master        bus,
   output logic [AW-1:0]   pc,
   output logic            halted,
   output logic [15:0]     icnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_retire;
   logic [AW-1:0] r_pc;
   logic [15:0]   r_ir;
   logic          r_halted;
   logic [15:0]   r_icnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Decoder outputs (h, pcwe) are only consulted in EXEC, so nothing is
   // acted on while the decoder sees a NOP.
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_next = S_EXEC;
         end
         S_EXEC: begin
            if (!stall) begin
               w_retire = 1'b1;
               w_next   = bus.h ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_ir     <= 16'h0000;
         r_halted <= 1'b0;
         r_icnt   <= 16'h0000;
      end else begin
         if (r_state == S_FETCH) begin
            r_ir <= bus.imem_rdata;
         end
         if (w_retire) begin
            if (r_icnt != 16'hFFFF) begin
               r_icnt <= r_icnt + 16'd1;
            end
            // HALT keeps the PC pointing at the halting instruction.
            if (bus.h) begin
               r_halted <= 1'b1;
            end else if (bus.pcwe) begin
               r_pc <= bus.br_tgt[AW-1:0];
            end else begin
               r_pc <= r_pc + AW'(1);
            end
         end
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.o         = (r_state == S_EXEC) ? r_ir : 16'h0000;
   assign bus.ir_vld    = (r_state == S_EXEC);
   assign pc            = r_pc;
   assign halted        = r_halted;
   assign icnt          = r_icnt;

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch and sequencing stage of the 16-bit pu core, directly upstream of the instruction decoder.
- Owns the program counter and drives the instruction-memory address.
- Latches the fetched word into an instruction register and presents it as the decoder's instruction input `o`.
- Consumes the decoder's `h` and `pcwe` outputs plus the ALU-computed branch target to choose the next PC, and stops the core on HALT.

Parameters:
- AW, 8: PC / instruction-memory address width in bits.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  start request; sampled only in IDLE.
- stall  in  1  holds the current instruction in EXEC (e.g. data-memory busy).
- imem_addr  out  AW  instruction-memory address; always equals pc.
- imem_rdata  in  16  instruction word; combinational read of imem_addr.
- o  out  16  instruction to decoder; IR value in EXEC, otherwise 16'h0000 (NOP).
- ir_vld  out  1  high only in EXEC; qualifies decoder write enables downstream.
- pc  out  AW  PC of the instruction currently held in the IR.
- h  in  1  halt indication from decoder.
- pcwe  in  1  PC write enable (taken branch) from decoder.
- br_tgt  in  16  branch target from ALU result.
- halted  out  1  core stopped by HALT.
- icnt  out  16  retired-instruction counter.

Behaviour:
- Reset is asynchronous and active-high. On rst: state=IDLE, pc=RESET_PC, ir=0, o=0, ir_vld=0, halted=0, icnt=0. Reset takes effect immediately in any state, including mid-EXEC or with stall high.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: o=0, ir_vld=0.
  - run=1 → FETCH on the next edge.
  - run=0 → stay in IDLE.
- FETCH: lasts exactly 1 cycle.
  - imem_addr=pc; ir <= imem_rdata at the end of the cycle.
  - Always → EXEC.
  - o=0, ir_vld=0 during FETCH.
- EXEC: o=ir, ir_vld=1. Decoder outputs are valid this cycle. Priority at the end of the cycle:
  1. stall=1: stay in EXEC; pc, ir and icnt held. stall overrides h and pcwe.
  2. h=1: → HALT; halted<=1; pc unchanged; icnt<=icnt+1. h overrides pcwe.
  3. pcwe=1: pc <= br_tgt[AW-1:0] (upper bits discarded); icnt++; → FETCH.
  4. Otherwise: pc <= pc+1, modulo 2^AW (all-ones wraps to 0); icnt++; → FETCH.
- HALT: o=0, ir_vld=0, halted=1. run, pcwe and h are ignored. Exit only via rst.
- Throughput: 2 cycles per instruction when not stalled.
- Latency: a run pulse in IDLE at edge N gives ir_vld=1 in the cycle after edge N+1.
- icnt saturates at 16'hFFFF (no wrap).
- run is ignored in FETCH, EXEC and HALT.
- pcwe outside EXEC is ignored.
- h and pcwe are sampled only in EXEC, so decoder outputs are never acted on while o=0.

Test Plan:
- Sequential run: imem[0..2]=16'h2401,16'h2402,16'h2403; rst, then 1-cycle run pulse → pc goes 0→1→2→3, with ir_vld high every second cycle and o matching each word; icnt=3 after the third EXEC.
- Taken branch (AW=8): instruction at pc=8'h05 with pcwe=1, br_tgt=16'h1234 in EXEC → next FETCH at imem_addr=8'h34; pc=8'h34; icnt+1.
- Halt: imem[4]=16'h0001, h=1 in EXEC with pcwe=1 simultaneously → halted=1 next cycle, pc stays 8'h04, o=0, ir_vld=0; later run pulses and pcwe leave all state unchanged.
- Stall: stall=1 for 3 cycles during EXEC of pc=8'h02 with h=1 asserted → stays in EXEC, o stable, pc=8'h02, icnt unchanged, halted=0; after stall drops, HALT is entered.
- Wrap: pc=8'hFF, non-branch EXEC → pc=8'h00, imem_addr=8'h00.
- Async reset mid-EXEC with stall=1: assert rst between edges → pc=RESET_PC, o=0, ir_vld=0, icnt=0, halted=0 immediately; FSM stays in IDLE until run.
